// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational logic/arithmetic unit between requesters A and B.
// Optional per-requester saturating grant counters are enabled with `define ALU_ARB_GRANT_CNT_EN.
//
// state | meaning
// IDLE  | waiting for a request; ready is offered to the round-robin winner
// EXEC  | operands held on alu_*; settle counter runs down to zero
// RESP  | result held on rsp_result; waiting for the winner's rsp_ready
module alu_share_arbiter #(
   parameter int W       = 32,
   parameter int OPW     = 3,
   parameter int ALU_LAT = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           a_valid,
   output logic           a_ready,
   input  logic [OPW-1:0] a_op,
   input  logic [W-1:0]   a_x,
   input  logic [W-1:0]   a_y,
   output logic           a_rsp_valid,
   input  logic           a_rsp_ready,
   input  logic           b_valid,
   output logic           b_ready,
   input  logic [OPW-1:0] b_op,
   input  logic [W-1:0]   b_x,
   input  logic [W-1:0]   b_y,
   output logic           b_rsp_valid,
   input  logic           b_rsp_ready,
   output logic [W-1:0]   rsp_result,
   output logic [OPW-1:0] alu_op,
   output logic [W-1:0]   alu_a,
   output logic [W-1:0]   alu_b,
   input  logic [W-1:0]   alu_r,
`ifdef ALU_ARB_GRANT_CNT_EN
   output logic [15:0]    grant_cnt_a,
   output logic [15:0]    grant_cnt_b,
`endif
   output logic           busy
);

   typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

   localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

   state_t         state_q, state_d;
   logic           gnt_q, gnt_d;     // 0 = A, 1 = B
   logic           last_q, last_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [OPW-1:0] op_q, op_d;
   logic [W-1:0]   x_q, x_d;
   logic [W-1:0]   y_q, y_d;
   logic [W-1:0]   res_q, res_d;
   logic           win_a, win_b;

   // A wins a tie only when B was served last
   assign win_a = a_valid && (!b_valid || last_q);
   assign win_b = b_valid && !win_a;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         op_q    <= '0;
         x_q     <= '0;
         y_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         x_q     <= x_d;
         y_q     <= y_d;
         res_q   <= res_d;
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      x_d     = x_q;
      y_d     = y_q;
      res_d   = res_q;
      a_ready = 1'b0;
      b_ready = 1'b0;
      case (state_q)
         IDLE: begin
            a_ready = win_a;
            b_ready = win_b;
            if (win_a || win_b) begin
               gnt_d   = win_b;
               last_d  = win_b;
               op_d    = win_b ? b_op : a_op;
               x_d     = win_b ? b_x  : a_x;
               y_d     = win_b ? b_y  : a_y;
               cnt_d   = LAT_M1;
               state_d = EXEC;
            end
         end
         EXEC: begin
            if (cnt_q == 4'd0) begin
               res_d   = alu_r;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            if (gnt_q ? b_rsp_ready : a_rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign a_rsp_valid = (state_q == RESP) && !gnt_q;
   assign b_rsp_valid = (state_q == RESP) &&  gnt_q;
   assign rsp_result  = res_q;
   assign alu_op      = op_q;
   assign alu_a       = x_q;
   assign alu_b       = y_q;
   assign busy        = (state_q != IDLE);

`ifdef ALU_ARB_GRANT_CNT_EN
   logic [15:0] gcnt_a_q, gcnt_b_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gcnt_a_q <= '0;
         gcnt_b_q <= '0;
      end else begin
         if (a_ready && gcnt_a_q != 16'hFFFF) gcnt_a_q <= gcnt_a_q + 16'd1;
         if (b_ready && gcnt_b_q != 16'hFFFF) gcnt_b_q <= gcnt_b_q + 16'd1;
      end
   end

   assign grant_cnt_a = gcnt_a_q;
   assign grant_cnt_b = gcnt_b_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed self-checking bench for alu_share_arbiter: one LAT=1 instance for protocol and
// fairness scenarios, one LAT=4 instance for settle timing.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_valid = 0, b_valid = 0, a_rsp_ready = 0, b_rsp_ready = 0;
   logic [2:0]  a_op = 0, b_op = 0;
   logic [31:0] a_x = 0, a_y = 0, b_x = 0, b_y = 0;
   logic        a_ready, b_ready, a_rsp_valid, b_rsp_valid, busy;
   logic [31:0] rsp_result, alu_a, alu_b;
   logic [2:0]  alu_op;
   logic [31:0] alu_r;

   logic        d4_a_valid = 0, d4_a_rsp_ready = 0;
   logic [31:0] d4_a_x = 0, d4_a_y = 0, d4_alu_r = 0;
   logic        d4_a_ready, d4_b_ready, d4_a_rsp_valid, d4_b_rsp_valid, d4_busy;
   logic [31:0] d4_rsp_result, d4_alu_a, d4_alu_b;
   logic [2:0]  d4_alu_op;

`ifdef ALU_ARB_GRANT_CNT_EN
   logic [15:0] grant_cnt_a, grant_cnt_b, d4_gca, d4_gcb;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   // Bench model of the shared unit: 0 AND, 1 OR, 2 XOR, 3 ADD
   always_comb begin
      case (alu_op)
         3'd0:    alu_r = alu_a & alu_b;
         3'd1:    alu_r = alu_a | alu_b;
         3'd2:    alu_r = alu_a ^ alu_b;
         3'd3:    alu_r = alu_a + alu_b;
         default: alu_r = 32'h0;
      endcase
   end

   alu_share_arbiter #(.W(32), .OPW(3), .ALU_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(a_ready), .a_op(a_op), .a_x(a_x), .a_y(a_y),
      .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready),
      .b_valid(b_valid), .b_ready(b_ready), .b_op(b_op), .b_x(b_x), .b_y(b_y),
      .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready),
      .rsp_result(rsp_result), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_r(alu_r),
`ifdef ALU_ARB_GRANT_CNT_EN
      .grant_cnt_a(grant_cnt_a), .grant_cnt_b(grant_cnt_b),
`endif
      .busy(busy)
   );

   alu_share_arbiter #(.W(32), .OPW(3), .ALU_LAT(4)) dut4 (
      .clk(clk), .rst_n(rst_n),
      .a_valid(d4_a_valid), .a_ready(d4_a_ready), .a_op(3'd2), .a_x(d4_a_x), .a_y(d4_a_y),
      .a_rsp_valid(d4_a_rsp_valid), .a_rsp_ready(d4_a_rsp_ready),
      .b_valid(1'b0), .b_ready(d4_b_ready), .b_op(3'd0), .b_x(32'h0), .b_y(32'h0),
      .b_rsp_valid(d4_b_rsp_valid), .b_rsp_ready(1'b0),
      .rsp_result(d4_rsp_result), .alu_op(d4_alu_op), .alu_a(d4_alu_a), .alu_b(d4_alu_b),
      .alu_r(d4_alu_r),
`ifdef ALU_ARB_GRANT_CNT_EN
      .grant_cnt_a(d4_gca), .grant_cnt_b(d4_gcb),
`endif
      .busy(d4_busy)
   );

   task automatic cyc();
      @(posedge clk); #1;
   endtask

   task automatic pulse_reset();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk); #1;
      tests++;
      if ({a_ready, b_ready, a_rsp_valid, b_rsp_valid, busy} !== 5'b0) begin
         fails++; $display("FAIL reset_ctrl got=%b want=00000", {a_ready, b_ready, a_rsp_valid, b_rsp_valid, busy});
      end
      tests++;
      if ({rsp_result, alu_a, alu_b, alu_op} !== 99'h0) begin
         fails++; $display("FAIL reset_data res=%h a=%h b=%h op=%h want 0", rsp_result, alu_a, alu_b, alu_op);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_a_only();
      @(negedge clk);
      a_valid = 1; a_op = 3'd2; a_x = 32'hFFFFFFFF; a_y = 32'h40A00400;
      #1;
      tests++;
      if ({a_ready, b_ready} !== 2'b10) begin
         fails++; $display("FAIL a_only_ready got=%b want=10", {a_ready, b_ready});
      end
      cyc(); a_valid = 0;
      tests++;
      if ({a_ready, busy, a_rsp_valid, alu_a, alu_b} !== {3'b010, 32'hFFFFFFFF, 32'h40A00400}) begin
         fails++; $display("FAIL a_only_exec rdy=%b busy=%b rv=%b a=%h b=%h", a_ready, busy, a_rsp_valid, alu_a, alu_b);
      end
      cyc();
      tests++;
      if ({a_rsp_valid, b_rsp_valid, rsp_result} !== {2'b10, 32'hBF5FFBFF}) begin
         fails++; $display("FAIL a_only_rsp av=%b bv=%b res=%h want 1 0 bf5ffbff", a_rsp_valid, b_rsp_valid, rsp_result);
      end
      a_rsp_ready = 1;
      cyc(); a_rsp_ready = 0;
      tests++;
      if ({a_rsp_valid, busy} !== 2'b00) begin
         fails++; $display("FAIL a_only_done av=%b busy=%b want 0 0", a_rsp_valid, busy);
      end
   endtask

   task automatic test_both_tie();
      pulse_reset();
      a_valid = 1; a_op = 3'd2; a_x = 32'h22220225; a_y = 32'hC2420423;
      b_valid = 1; b_op = 3'd2; b_x = 32'h0;        b_y = 32'h1;
      #1;
      tests++;
      if ({a_ready, b_ready} !== 2'b10) begin
         fails++; $display("FAIL tie_first got=%b want=10", {a_ready, b_ready});
      end
      cyc(); a_valid = 0;
      cyc();
      tests++;
      if ({a_rsp_valid, b_ready, rsp_result} !== {2'b10, 32'hE0600606}) begin
         fails++; $display("FAIL tie_a_rsp av=%b brdy=%b res=%h want 1 0 e0600606", a_rsp_valid, b_ready, rsp_result);
      end
      a_rsp_ready = 1;
      cyc(); a_rsp_ready = 0;
      tests++;
      if (b_ready !== 1'b1) begin
         fails++; $display("FAIL tie_b_ready got=%b want=1", b_ready);
      end
      cyc(); b_valid = 0;
      cyc();
      tests++;
      if ({b_rsp_valid, a_rsp_valid, rsp_result} !== {2'b10, 32'h00000001}) begin
         fails++; $display("FAIL tie_b_rsp bv=%b av=%b res=%h want 1 0 00000001", b_rsp_valid, a_rsp_valid, rsp_result);
      end
      b_rsp_ready = 1;
      cyc(); b_rsp_ready = 0;
      a_valid = 1; b_valid = 1;
      #1;
      tests++;
      if ({a_ready, b_ready} !== 2'b10) begin
         fails++; $display("FAIL tie_next got=%b want=10", {a_ready, b_ready});
      end
      a_valid = 0; b_valid = 0;
`ifdef ALU_ARB_GRANT_CNT_EN
      tests++;
      if ({grant_cnt_a, grant_cnt_b} !== {16'd1, 16'd1}) begin
         fails++; $display("FAIL tie_gcnt a=%0d b=%0d want 1 1", grant_cnt_a, grant_cnt_b);
      end
`endif
   endtask

   task automatic test_fairness();
      logic [5:0] order;
      int         idles;
      int         n;
      order = '0; idles = 0; n = 0;
      @(negedge clk);
      a_valid = 1; a_op = 3'd3; a_x = 32'd5; a_y = 32'd7;
      b_valid = 1; b_op = 3'd1; b_x = 32'hF0; b_y = 32'h0F;
      a_rsp_ready = 1; b_rsp_ready = 1;
      for (int i = 0; i < 18; i++) begin
         #1;
         if (!busy) begin
            idles++;
            if (n < 6) order[n] = b_ready;
            n++;
         end
         if (i == 17) begin a_valid = 0; b_valid = 0; end
         @(negedge clk);
      end
      a_rsp_ready = 0; b_rsp_ready = 0;
      tests++;
      if (order !== 6'b101010 || n != 6) begin
         fails++; $display("FAIL fair_order got=%b n=%0d want=101010 n=6", order, n);
      end
      tests++;
      if (idles != 6) begin
         fails++; $display("FAIL fair_idle got=%0d want=6", idles);
      end
   endtask

   task automatic test_lat4();
      int edges;
      logic stable;
      edges = 0; stable = 1;
      @(negedge clk);
      d4_a_valid = 1; d4_a_x = 32'h12345678; d4_a_y = 32'h9ABCDEF0;
      cyc(); d4_a_valid = 0;
      d4_alu_r = 32'h11111111;
      while (!d4_a_rsp_valid && edges < 10) begin
         if (d4_alu_a !== 32'h12345678 || d4_alu_b !== 32'h9ABCDEF0) stable = 0;
         cyc(); edges++;
         if (edges == 1) d4_alu_r = 32'h22222222;
         if (edges == 2) d4_alu_r = 32'h33333333;
         if (edges == 3) d4_alu_r = 32'hCAFEF00D;
      end
      tests++;
      if (edges != 4) begin
         fails++; $display("FAIL lat4_edges got=%0d want=4", edges);
      end
      tests++;
      if (d4_rsp_result !== 32'hCAFEF00D) begin
         fails++; $display("FAIL lat4_result got=%h want=cafef00d", d4_rsp_result);
      end
      tests++;
      if (stable !== 1'b1) begin
         fails++; $display("FAIL lat4_stable got=%b want=1", stable);
      end
      d4_a_rsp_ready = 1;
      cyc(); d4_a_rsp_ready = 0;
   endtask

   task automatic test_hold_resp();
      logic ok;
      ok = 1;
      @(negedge clk);
      a_valid = 1; a_op = 3'd0; a_x = 32'hFF00FF00; a_y = 32'h0FF00FF0;
      cyc(); a_valid = 0; b_valid = 1; b_op = 3'd3; b_x = 32'd100; b_y = 32'd23;
      cyc();
      for (int i = 0; i < 5; i++) begin
         if (a_rsp_valid !== 1'b1 || b_ready !== 1'b0 || b_rsp_valid !== 1'b0 ||
             rsp_result !== 32'h0F000F00) ok = 0;
         cyc();
      end
      tests++;
      if (ok !== 1'b1) begin
         fails++; $display("FAIL hold_resp av=%b brdy=%b res=%h want 1 0 0f000f00", a_rsp_valid, b_ready, rsp_result);
      end
      a_rsp_ready = 1;
      cyc(); a_rsp_ready = 0;
      tests++;
      if ({a_rsp_valid, b_ready} !== 2'b01) begin
         fails++; $display("FAIL hold_b_accept av=%b brdy=%b want 0 1", a_rsp_valid, b_ready);
      end
      cyc(); b_valid = 0;
      cyc();
      tests++;
      if ({b_rsp_valid, rsp_result} !== {1'b1, 32'd123}) begin
         fails++; $display("FAIL hold_b_rsp bv=%b res=%0d want 1 123", b_rsp_valid, rsp_result);
      end
      b_rsp_ready = 1;
      cyc(); b_rsp_ready = 0;
   endtask

   task automatic test_reset_exec();
      logic seen;
      seen = 0;
      @(negedge clk);
      a_valid = 1; a_op = 3'd1; a_x = 32'hA5A5A5A5; a_y = 32'h1;
      cyc(); a_valid = 0;
      rst_n = 0; #1;
      tests++;
      if ({busy, a_ready, b_ready, a_rsp_valid, b_rsp_valid, rsp_result, alu_a, alu_b, alu_op} !== 104'h0) begin
         fails++; $display("FAIL rst_exec busy=%b av=%b res=%h a=%h b=%h", busy, a_rsp_valid, rsp_result, alu_a, alu_b);
      end
`ifdef ALU_ARB_GRANT_CNT_EN
      tests++;
      if ({grant_cnt_a, grant_cnt_b} !== 32'h0) begin
         fails++; $display("FAIL rst_gcnt a=%0d b=%0d want 0 0", grant_cnt_a, grant_cnt_b);
      end
`endif
      @(negedge clk); rst_n = 1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (a_rsp_valid || b_rsp_valid || busy) seen = 1;
      end
      tests++;
      if (seen !== 1'b0) begin
         fails++; $display("FAIL rst_no_rsp got=%b want=0", seen);
      end
   endtask

   initial begin
      test_reset();
      test_a_only();
      test_both_tie();
      test_fairness();
      test_lat4();
      test_hold_resp();
      test_reset_exec();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog sim time exceeded");
      $fatal(1);
   end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one external combinational 32-bit logic/arithmetic unit (AND/OR/XOR/ADD class) between two requesters, A and B.
- Arbitrates round-robin, latches the winner's operands and opcode, and drives the unit for a programmable number of settle cycles.
- Captures the result and returns it to the winner over a valid/ready handshake.
- Sits between the decode/execute control and the shared logic datapath of the MiniMIPS core.

Parameters:
- W, 32, operand/result width.
- OPW, 3, opcode width. Opcode is passed to the unit unchanged; the arbiter never decodes it.
- ALU_LAT, 1, settle cycles in EXEC before the result is sampled. Legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- a_valid  in  1  requester A has an operation.
- a_ready  out  1  A's request accepted this cycle.
- a_op  in  OPW  A opcode.
- a_x  in  W  A operand 1.
- a_y  in  W  A operand 2.
- a_rsp_valid  out  1  result ready for A.
- a_rsp_ready  in  1  A consumes result.
- b_valid, b_ready, b_op, b_x, b_y, b_rsp_valid, b_rsp_ready: same as A, for requester B.
- rsp_result  out  W  registered result; valid while either rsp_valid is high.
- alu_op  out  OPW  to shared unit.
- alu_a  out  W  to shared unit.
- alu_b  out  W  to shared unit.
- alu_r  in  W  from shared unit, combinational result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, EXEC, RESP; 2-bit state register; reset state IDLE.
- Reset (asynchronous, rst_n low):
  - state=IDLE, last_grant=B (so A wins the first tie).
  - All ready/rsp_valid outputs 0.
  - rsp_result, alu_op, alu_a, alu_b = 0.
  - Settle counter 0.
- Reset mid-operation aborts the operation and discards any pending response. No response is ever issued for it.
- IDLE:
  - a_ready/b_ready are combinational from the valids and are high only in IDLE.
  - Only one requester wins:
    - A only valid → grant A.
    - B only valid → grant B.
    - Both valid → grant the one not equal to last_grant.
  - On the accepting edge:
    - Latch op/x/y of the winner into alu_op/alu_a/alu_b (registered outputs).
    - Record the winner in gnt and last_grant.
    - Load the counter with ALU_LAT-1.
    - Go to EXEC.
  - Neither valid → stay in IDLE; alu_* hold their last values.
- EXEC:
  - alu_* stable for exactly ALU_LAT cycles.
  - Counter decrements each cycle.
  - On the edge where counter==0, sample alu_r into rsp_result and go to RESP.
- RESP:
  - Assert <gnt>_rsp_valid; the other rsp_valid stays 0.
  - rsp_result is held stable.
  - The edge with <gnt>_rsp_ready=1 moves to IDLE; rsp_valid drops the following cycle.
  - rsp_ready of the non-granted requester is ignored.
- Timing, with request accepted at edge t0:
  - rsp_valid is high from edge t0+ALU_LAT.
  - With immediate rsp_ready, the earliest next accept is edge t0+ALU_LAT+2.
- Requests arriving or changing while busy are not sampled. A requester must hold valid and its data until ready.
- Fairness: with both requesters continuously valid, grants alternate A,B,A,B. Neither requester waits more than one foreign operation.
- No arithmetic inside the block; width is fixed at W. No wrap or overflow handling is needed beyond the counter.

Optional Feature:
- Macro ALU_ARB_GRANT_CNT_EN.
- When defined, adds two ports:
  - grant_cnt_a  out  16
  - grant_cnt_b  out  16
- Each counter increments on every accept edge for its requester and saturates at 0xFFFF (no wrap). Both reset to 0 asynchronously.
- When undefined, the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- A only, a_op=XOR, a_x=0xFFFFFFFF, a_y=0x40A00400, ALU_LAT=1, bench XOR model:
  - a_ready pulses 1 cycle.
  - a_rsp_valid rises 1 edge after accept.
  - rsp_result=0xBF5FFBFF.
  - b_rsp_valid stays 0.
- Both valid in the same cycle from reset, A: 0x22220225^0xC2420423, B: 0x0^0x1:
  - A served first, result 0xE0600606.
  - Then B, result 0x00000001.
  - Next simultaneous request goes to A again.
- Both held valid for 6 operations → grant order A,B,A,B,A,B; busy stays high except the single IDLE cycles.
- ALU_LAT=4; bench alu_r model changes value during settle cycles 1..3:
  - rsp_valid at accept+4 edges.
  - The captured value equals alu_r of cycle 4.
  - alu_a/alu_b stable throughout.
- RESP with a_rsp_ready held 0 for 5 cycles while b_valid=1:
  - a_rsp_valid and rsp_result hold.
  - b_ready stays 0.
  - After a_rsp_ready=1, B is accepted 1 cycle later.
- rst_n pulsed low during EXEC → all outputs 0 immediately; no rsp_valid follows. With ALU_ARB_GRANT_CNT_EN defined, the counters also clear.
